demux_18_seq: RTL and testbench
===============================

Name: demux_18_seq

Overview:
- Sequential 1-to-8 demultiplexer (serial-to-parallel deserializer); receiving end of the 8:1 select-mux serializer.
- Each accepted serial bit is routed into slot `sel` of a shadow word, with `sel` advanced by an internal counter.
- A completed 8-bit word is presented on `y` with a one-cycle `y_valid` strobe.
- Sits between a serial link (driven by a counter-selected 8:1 mux) and parallel consumer logic.

Parameters:
- WIDTH, 8, number of output slots (power of two, ≥2).
- SEL_W, 3, select/counter width, equal to log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  1  serial data bit.
- din_valid  input  1  `din` carries a bit this cycle.
- start  input  1  frame sync; marks the current `din` as the slot-0 bit; only meaningful with `din_valid`=1.
- y  output  WIDTH  last completed word; slot k is `y[k]`.
- y_valid  output  1  one-cycle pulse when `y` is updated.
- sel  output  SEL_W  slot the next accepted bit will fill.
- busy  output  1  frame in progress (state COLLECT).
- frame_err  output  1  one-cycle pulse: partial frame aborted by a new `start`.

Behaviour:
- One clock domain. Asynchronous active-low reset.
- All outputs are registered.
- Reset values: `y`=0, `y_valid`=0, `sel`=0, `busy`=0, `frame_err`=0, shadow word=0, state=IDLE.
- Reset asserted mid-frame discards the partial word; `y` returns to 0.
- States: IDLE, COLLECT.
- IDLE:
  - `din_valid`=1 and `start`=1: shadow[0]<=`din`; `sel`<=1; go to COLLECT.
  - `din_valid`=1 and `start`=0: bit ignored, no state change.
  - `start`=1 with `din_valid`=0: ignored.
- COLLECT, on `din_valid`=1 and `start`=0:
  - shadow[`sel`]<=`din`; `sel`<=`sel`+1.
  - If `sel`==WIDTH-1: `y`<={`din`, shadow[WIDTH-2:0]}, `y_valid`<=1, `sel`<=0 (wrap), go to IDLE.
- COLLECT, on `din_valid`=1 and `start`=1 (resync):
  - `frame_err`<=1; shadow[0]<=`din`; `sel`<=1; stay in COLLECT.
  - `y` is unchanged and there is no `y_valid`.
- COLLECT, on `din_valid`=0: hold all state; gaps are allowed with no timeout.
- Latency: `y`/`y_valid` change on the clock edge that samples the slot-(WIDTH-1) bit. They are visible the cycle after that bit is presented.
- `y` holds its value between completions. `y_valid` and `frame_err` are single-cycle pulses.
- Back-to-back frames: a `start` in the cycle immediately after completion (state IDLE) is accepted normally with zero dead cycles.
- Unused shadow slots are never written outside the decoded slot.
- `busy`=1 exactly while the state is COLLECT.

Decomposition:
- Shared package demux_pkg:
  - state enum {IDLE, COLLECT}.
  - Default WIDTH/SEL_W constants.
  - A clog2-based SEL_W helper.
- One natural sub-module, demux_dec: combinational `sel` -> WIDTH one-hot write-enable decoder, gated by `din_valid`. It is the inverse of the 8:1 mux select.
- The FSM, counter and shadow/output registers stay in demux_18_seq.

Test Plan:
- Reset then bits 1,0,1,1,0,0,1,0 (slot0 first, `start` on the first bit, `din_valid` continuous) -> `y`=8'h4D, `y_valid` high for exactly 1 cycle, one cycle after the 8th bit; `busy` high for cycles 1..7; `sel` back to 0.
- Same frame with `din_valid` low for 3 cycles between bits 4 and 5 -> `y`=8'h4D, `sel` holds 4 during the gap, no spurious `y_valid`.
- Three back-to-back frames 8'hA5, 8'hFF, 8'h00 with no idle cycles -> three `y_valid` pulses exactly 8 cycles apart, `y` sequence A5, FF, 00.
- Partial frame of 5 bits, then `start` with a new frame 8'h3C -> `frame_err` pulses once on the resync bit; `y` keeps its previous value until 8'h3C completes; single `y_valid`.
- `din_valid`=1, `start`=0 in IDLE for 10 cycles with `din`=1 -> no state change, `sel`=0, `busy`=0, `y` unchanged.
- `rst_n` pulsed low asynchronously after bit 6 of a frame -> all outputs 0 immediately; the next full frame 8'h81 completes correctly as `y`=8'h81.

Source files
------------

// File: rtl/demux_18_seq_pkg.sv
// Shared types and sizing constants for the serial-to-parallel demultiplexer.
package demux_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_SEL_W = 3;

    // Slot-select width for a given number of output slots (at least one bit).
    function automatic int sel_w_for(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/demux_18_seq_if.sv
// Serial input / parallel output bundle for demux_18_seq.
// Handshake: din is consumed on every rising edge where din_valid=1 (no back-pressure);
// y_valid and frame_err are single-cycle strobes, y holds between strobes.
interface demux_18_seq_if
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEL_W = DEFAULT_SEL_W
) ();
    logic             din;
    logic             din_valid;
    logic             start;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             frame_err;
    state_e           state;

    modport master (
        output din, din_valid, start,
        input  y, y_valid, sel, busy, frame_err, state
    );

    modport slave (
        input  din, din_valid, start,
        output y, y_valid, sel, busy, frame_err, state
    );
endinterface

// File: rtl/demux_18_seq_dec.sv
// Slot-select to one-hot write-enable decoder; inverse of the serializer's 8:1 mux select.
module demux_dec #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [WIDTH-1:0] we
);
    always_comb begin
        we = '0;
        if (en) begin
            we[sel] = 1'b1;
        end
    end
endmodule

// File: rtl/demux_18_seq.sv
// Sequential 1-to-WIDTH demultiplexer: collects a framed serial stream into a shadow
// word and publishes each completed word on y with a one-cycle y_valid strobe.
module demux_18_seq
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEL_W = DEFAULT_SEL_W
) (
    input logic            clk,
    input logic            rst_n,
    demux_18_seq_if.slave  bus
);
    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;

    logic [SEL_W-1:0] wr_slot;
    logic             wr_en;
    logic [WIDTH-1:0] we;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        y_d         = y_q;
        y_valid_d   = 1'b0;
        frame_err_d = 1'b0;
        wr_slot     = '0;
        wr_en       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.din_valid && bus.start) begin
                    wr_en   = 1'b1;
                    sel_d   = SEL_W'(1);
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.din_valid) begin
                    wr_en = 1'b1;
                    if (bus.start) begin
                        // Resync: restart the frame at slot 0, y is left untouched.
                        frame_err_d = 1'b1;
                        sel_d       = SEL_W'(1);
                    end else begin
                        wr_slot = sel_q;
                        if (sel_q == SEL_W'(WIDTH - 1)) begin
                            y_d       = {bus.din, shadow_q[WIDTH-2:0]};
                            y_valid_d = 1'b1;
                            sel_d     = '0;
                            state_d   = IDLE;
                        end else begin
                            sel_d = sel_q + SEL_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == COLLECT);
    end

    demux_dec #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_dec (
        .sel (wr_slot),
        .en  (wr_en),
        .we  (we)
    );

    always_comb begin
        shadow_d = shadow_q;
        for (int k = 0; k < WIDTH; k++) begin
            if (we[k]) begin
                shadow_d[k] = bus.din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            shadow_q    <= '0;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            shadow_q    <= shadow_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.y         = y_q;
    assign bus.y_valid   = y_valid_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = frame_err_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_demux_18_seq.sv
// Randomized and directed bench for demux_18_seq with a bit-queue reference model and
// a negedge monitor that scores words, strobes, busy and sel.
module tb_demux_18_seq;
    import demux_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux_18_seq_if #(.WIDTH(W), .SEL_W(3)) bus ();

    demux_18_seq #(.WIDTH(W), .SEL_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues: expected words with the cycle they must appear, and expected resync strobes.
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    int           err_cyc_q[$];

    // Reference model: the bits of the current frame, slot 0 first.
    bit           mdl_bits[$];
    bit           mdl_in_frame = 1'b0;
    int           exp_busy = 0;
    int           exp_sel = 0;
    logic [W-1:0] last_y = '0;
    bit           chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_bit(input bit v, input bit st, input bit d);
        logic [W-1:0] word;
        if (!v) return;
        if (st) begin
            if (mdl_in_frame) err_cyc_q.push_back(cyc + 1);
            mdl_bits.delete();
            mdl_bits.push_back(d);
            mdl_in_frame = 1'b1;
        end else if (mdl_in_frame) begin
            mdl_bits.push_back(d);
            if (mdl_bits.size() == W) begin
                word = '0;
                for (int k = 0; k < W; k++) word = word | (W'(mdl_bits[k]) << k);
                exp_q.push_back(word);
                exp_cyc_q.push_back(cyc + 1);
                mdl_bits.delete();
                mdl_in_frame = 1'b0;
            end
        end
    endtask

    // One clock of stimulus; also snapshots what the monitor should see this cycle.
    task automatic step(input bit v, input bit st, input bit d);
        @(posedge clk);
        exp_busy = mdl_in_frame ? 1 : 0;
        exp_sel  = mdl_in_frame ? mdl_bits.size() : 0;
        #1;
        bus.din_valid = v;
        bus.start     = st;
        bus.din       = d;
        model_bit(v, st, d);
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap_at, input int gap_len);
        for (int k = 0; k < W; k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            end
            step(1'b1, (k == 0), w[k]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (bus.y_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_y_valid", 32'(bus.y_valid), 32'd0);
                end else begin
                    logic [W-1:0] w;
                    int           c;
                    w = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    check("y_word", 32'(bus.y), 32'(w));
                    check("y_latency", 32'(cyc), 32'(c));
                    last_y = w;
                end
            end else begin
                check("y_hold", 32'(bus.y), 32'(last_y));
            end
            if (bus.frame_err) begin
                if (err_cyc_q.size() == 0) check("spurious_frame_err", 32'(bus.frame_err), 32'd0);
                else check("frame_err_cycle", 32'(cyc), 32'(err_cyc_q.pop_front()));
            end
            check("busy", 32'(bus.busy), 32'(exp_busy));
            check("sel", 32'(bus.sel), 32'(exp_sel));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.din = 1'b0;
        bus.din_valid = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_y", 32'(bus.y), 32'd0);
        check("rst_y_valid", 32'(bus.y_valid), 32'd0);
        check("rst_sel", 32'(bus.sel), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        idle(2);

        send_word(8'h4D, -1, 0);
        idle(3);
        send_word(8'h4D, 4, 3);
        idle(2);
        send_word(8'hA5, -1, 0);
        send_word(8'hFF, -1, 0);
        send_word(8'h00, -1, 0);
        idle(2);

        for (int k = 0; k < 5; k++) step(1'b1, (k == 0), 1'($urandom_range(0, 1)));
        send_word(8'h3C, -1, 0);
        idle(2);

        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1);
        idle(1);

        // Asynchronous reset in the middle of a frame, after its 6th bit.
        for (int k = 0; k < 6; k++) step(1'b1, (k == 0), 1'($urandom_range(0, 1)));
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        bus.start = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_y", 32'(bus.y), 32'd0);
        check("async_rst_sel", 32'(bus.sel), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_y_valid", 32'(bus.y_valid), 32'd0);
        mdl_bits.delete();
        mdl_in_frame = 1'b0;
        exp_busy = 0;
        exp_sel = 0;
        last_y = '0;
        #1;
        rst_n = 1'b1;
        idle(1);
        send_word(8'h81, -1, 0);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
        end
        idle(4);

        check("pending_words", 32'(exp_q.size()), 32'd0);
        check("pending_frame_errs", 32'(err_cyc_q.size()), 32'd0);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
